instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction ROM and downstream-feeding the decoder.
- Owns the PC and drives the ROM word address.
- Captures the combinational ROM read data into a small fetch queue, so decode back-pressure never stalls address generation mid-word.
- Handles control-flow redirects from execute by flushing the queue and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QDEPTH, 2, fetch queue entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- iAddr  out  32  byte address to instruction ROM; equals the pc register (combinational from register only).
- iData  in  32  ROM read data for iAddr, valid same cycle.
- redirect_valid  in  1  one-cycle pulse: branch/jump taken, load new PC.
- redirect_pc  in  32  target address accompanying redirect_valid.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decoder accepts head this cycle.
- out_instr  out  32  instruction word at queue head.
- out_pc  out  32  address of out_instr.
- out_pc4  out  32  out_pc + 4, wraps modulo 2^32.
- fetch_fault  out  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset, checked at the clock edge only:
  - pc <= RESET_PC; queue count <= 0.
  - out_valid=0; fetch_fault=0; out_instr/out_pc/out_pc4 = 0.
- pop = out_valid & out_ready.
- push = !redirect_valid & !fault_hold & (count < QDEPTH | pop).
- On push:
  - Enqueue {pc, iData}; pc <= pc + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - Otherwise pc holds.
- Latency: the word at iAddr=A appears on out_* the cycle after the edge that captured it. Minimum one cycle from reset release to the first out_valid.
- Full with pop in the same cycle: push and pop both occur; count unchanged; back-to-back throughput of 1 instruction/cycle.
- Empty: out_valid=0; out_* hold last values (don't-care to consumer).
- Redirect has highest priority:
  - count <= 0; pc <= redirect_pc; no push that cycle.
  - A pop handshake in the redirect cycle counts as consumed by the decoder.
  - out_valid=0 the following cycle; the target instruction appears one cycle later (2-cycle redirect penalty).
- reset and redirect_valid together: reset wins.
- Queue order is strict FIFO; read/write pointers wrap modulo QDEPTH.
- No combinational path from out_ready or redirect_* to iAddr.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined, on redirect with redirect_pc[1:0] != 0:
  - pc <= redirect_pc and fetch_fault <= 1 (sticky); fault_hold=1 inhibits push.
  - Cleared by reset or by a subsequent redirect with an aligned target.
- Undefined:
  - redirect_pc[1:0] forced to 2'b00 when loaded.
  - fetch_fault tied 0; fault_hold always 0.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr}.
  - XLEN=32; PC_STEP=4; NOP_INSTR=32'h0000_0013.
- Sub-module fetch_queue:
  - Synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Parameterised by QDEPTH.
- instr_fetch_unit holds the PC logic, push/pop arbitration and fault logic.

Test Plan:
- Reset then out_ready=1 constantly, ROM preloaded with 5 words -> out_pc sequence 0,4,8,12,16 on consecutive cycles; first out_valid one cycle after reset deasserts; out_instr matches ROM[0..4].
- out_ready=0 for 6 cycles -> count saturates at 2, iAddr stops at 8; release -> PCs 0,4,8 delivered in order, none dropped or duplicated.
- redirect_valid with redirect_pc=32'h40 while queue full -> next cycle out_valid=0, iAddr=0x40; following cycle out_pc=0x40, out_pc4=0x44.
- reset asserted mid-stream together with redirect to 0x80 -> iAddr=RESET_PC, out_valid=0, redirect ignored.
- PC forced via redirect to 32'hFFFF_FFFC -> next fetched out_pc=0xFFFF_FFFC, out_pc4=0, then out_pc=0.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h22 -> fetch_fault=1, no further pushes; aligned redirect to 0x20 clears it. Without the macro, iAddr=0x20 and fetch_fault stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; head is read straight
// from storage so a captured word is visible the cycle after its write edge.
import fetch_pkg::*;

module fetch_queue #(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    fetch_entry_t  mem_q [QDEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok_s, pop_ok_s;

    assign empty_o   = (cnt_q == {CW{1'b0}});
    assign full_o    = (cnt_q == DEPTH_C);
    assign head_o    = mem_q[rd_q];
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);

    // Pointer and occupancy next-state; flush returns the queue to empty.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = {PW{1'b0}};
            wr_d  = {PW{1'b0}};
            cnt_d = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_d = wr_q + PW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_ok_s) begin
                rd_d = rd_q + PW'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= {PW{1'b0}};
            wr_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push_ok_s && !flush_i) begin
                mem_q[wr_q] <= entry_i;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, ROM capture into fetch_queue, redirect handling.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
import fetch_pkg::*;

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iAddr,
    input  logic [31:0] iData,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        fetch_fault
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic            seen_q, seen_d;
    logic            fault_hold_s, full_s, empty_s, push_s, pop_s;
    fetch_entry_t    head_s, wr_entry_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fault_hold_s = fault_q;
`else
    assign fault_hold_s = 1'b0;
`endif

    assign iAddr       = pc_q;
    assign out_valid   = ~empty_s;
    assign pop_s       = out_valid & out_ready;
    assign push_s      = ~redirect_valid & ~fault_hold_s & (~full_s | pop_s);
    assign wr_entry_s  = '{pc: pc_q, instr: iData};
    assign out_instr   = head_s.instr;
    assign out_pc      = head_s.pc;
    // Storage resets to zero, but pc+4 of a zero entry is not; mask until first fetch.
    assign out_pc4     = seen_q ? (head_s.pc + PC_STEP) : {XLEN{1'b0}};
    assign fetch_fault = fault_q;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (redirect_valid),
        .entry_i (wr_entry_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .head_o  (head_s)
    );

    // PC, fault and first-fetch next-state; redirect outranks sequential fetch.
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        seen_d  = seen_q;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d    = redirect_pc;
            fault_d = (redirect_pc[1:0] != 2'b00);
`else
            pc_d    = redirect_pc & ~32'h0000_0003;
            fault_d = 1'b0;
`endif
        end else if (push_s) begin
            pc_d   = pc_q + PC_STEP;
            seen_d = 1'b1;
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch-stage state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
            seen_q  <= seen_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Table-driven bench for instr_fetch_unit with a behavioural ROM.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, out_ready;
    logic [31:0] iAddr, iData, redirect_pc;
    logic        out_valid, fetch_fault;
    logic [31:0] out_instr, out_pc, out_pc4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        chk_out;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_iaddr;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_0013;
    endfunction

    assign iData = rom_f(iAddr);

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .iAddr          (iAddr),
        .iData          (iData),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .fetch_fault    (fetch_fault)
    );

    function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic chk, input logic ev,
                                input logic [31:0] epc, input logic [31:0] epc4,
                                input logic [31:0] eia, input logic ef);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.chk_out = chk;
        v.e_valid = ev; v.e_pc = epc; v.e_pc4 = epc4; v.e_iaddr = eia; v.e_fault = ef;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    initial begin
        logic [39:0] pat;
        logic [31:0] next_pc;
        int          delivered, want;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

        //           rst   rv    rpc           rdy   chk   ev    e_pc          e_pc4         e_iaddr       ef
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        32'h4,        32'h4,        1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4,        32'h8,        32'h8,        1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8,        32'hC,        32'hC,        1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        32'h10,       32'h10,       1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h10,       32'h14,       32'h14,       1'b0));
        // reset together with redirect: reset wins
        vecs.push_back(mk(1'b1, 1'b1, 32'h80,       1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0));
        // six stall cycles: queue fills with 0,4 and iAddr parks at 8
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        32'h4,        32'h4,        1'b0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0,        32'h4,        32'h8,        1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4,        32'h8,        32'hC,        1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8,        32'hC,        32'h10,       1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,        32'hC,        32'h10,       1'b0));
        // redirect while full
        vecs.push_back(mk(1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h40,       1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h40,       32'h44,       32'h44,       1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h44,       32'h48,       32'h48,       1'b0));
        // redirect to top of address space, with a pop in the same cycle
        vecs.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0,       32'h0,        32'hFFFF_FFFC, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,       32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        32'h4,        32'h4,        1'b0));
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 1'b1, 32'h22,       1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h22,       1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h22,       1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h22,       1'b1));
`else
        vecs.push_back(mk(1'b0, 1'b1, 32'h22,       1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h20,       1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h20,       32'h24,       32'h24,       1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h24,       32'h28,       32'h28,       1'b0));
`endif
        vecs.push_back(mk(1'b0, 1'b1, 32'h20,       1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h20,       1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h20,       32'h24,       32'h24,       1'b0));

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk(i, "out_valid", {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            chk(i, "iAddr", iAddr, vecs[i].e_iaddr);
            chk(i, "fetch_fault", {31'd0, fetch_fault}, {31'd0, vecs[i].e_fault});
            if (vecs[i].chk_out) begin
                chk(i, "out_pc", out_pc, vecs[i].e_pc);
                chk(i, "out_pc4", out_pc4, vecs[i].e_pc4);
                chk(i, "out_instr", out_instr,
                    vecs[i].e_valid ? rom_f(vecs[i].e_pc) : 32'h0);
            end
        end

        // Irregular decoder back-pressure: strict in-order delivery, one per accepted cycle.
        reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        pat       = 40'b1011_0011_1000_1101_0110_0111_0001_1110_1101_0101;
        next_pc   = 32'h0;
        delivered = 0;
        want      = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = pat[c];
            if (c > 0 && pat[c]) want++;
            if (out_valid && out_ready) begin
                chk(100 + c, "fifo_order_pc", out_pc, next_pc);
                chk(100 + c, "fifo_order_instr", out_instr, rom_f(next_pc));
                next_pc = next_pc + 32'd4;
                delivered++;
            end
            @(posedge clk); #1;
        end
        chk(200, "delivered_count", delivered, want);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
